sddr_bank_sched: RTL and testbench
==================================

Name: sddr_bank_sched

Overview:
- Parametrised DDR3 command scheduler; successor to the single-access DDR sequencer.
- Takes one bank/row/column request at a time and issues ACT/RD/WR/PRE/REF commands to the PHY-side command pins.
- Tracks an open row per bank (open-page policy) and issues periodic auto-refresh.
- Sits between the data-port arbiter and the DDR3 PHY. Data movement is signalled by a one-cycle issue strobe.

Parameters:
- BANK_BITS, 3, bank address width; 2**BANK_BITS banks tracked.
- ROW_BITS, 13, row address width; must be >= 11.
- COL_BITS, 10, column address width; must be <= 10.
- TIMER_BITS, 8, width of the tRCD/tRP/tRFC/tCCD timing inputs.
- REFI_BITS, 16, width of the refresh interval input.

Ports:
- ddr_clock_i  in  1  sole clock; all logic on posedge.
- reset_i  in  1  asynchronous, active-high reset.
- cfg_enable_i  in  1  scheduler enable; when low, no new requests and refresh timer held.
- cfg_trcd_i / cfg_trp_i / cfg_trfc_i / cfg_tccd_i  in  TIMER_BITS each  gaps in cycles.
- cfg_trefi_i  in  REFI_BITS  refresh interval in cycles.
- cmd_valid_i  in  1  request valid.
- cmd_ready_o  out  1  request accepted when cmd_valid_i && cmd_ready_o.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_bank_i  in  BANK_BITS  request bank.
- cmd_row_i  in  ROW_BITS  request row.
- cmd_col_i  in  COL_BITS  request column.
- ddr3_cmd_o  out  4  {CS,RAS,CAS,WE}, registered.
- ddr3_ba_o  out  BANK_BITS  registered.
- ddr3_addr_o  out  ROW_BITS  registered.
- issue_valid_o  out  1  one-cycle pulse, coincident with RD/WR on ddr3_cmd_o.
- issue_write_o  out  1  qualifies issue_valid_o; 1 = WR.
- refresh_busy_o  out  1  high from refresh-pending until the post-REF tRFC wait expires.

Behaviour:
- Command encodings: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001.
- Reset values: ddr3_cmd_o=NOP; ba, addr, issue_valid_o, issue_write_o, refresh_busy_o = 0; cmd_ready_o=0.
- On reset: open-row table cleared (all banks closed), gap timer 0, refresh counter loaded from cfg_trefi_i, state IDLE.
- Any cycle with no command issued drives NOP, ba=0, addr=0.
- States and transitions:
  - IDLE: on accept, latch the request, then go to RDWR on a row hit (bank open, same row), PRE on a row miss (bank open, different row), or ACT if the bank is closed.
  - PRE: issue PRE to the bank with A10=0; mark the bank closed; then ACT.
  - ACT: issue ACT with ba=bank, addr=row; record the row as open; then RDWR.
  - RDWR: issue RD/WR with addr[9:0]=col, A10=auto-precharge bit, other bits 0; pulse issue_valid_o; then IDLE.
  - REF_PRE: issue PRE-all (A10=1, ba=0); then REF.
  - REF: issue REF; clear the table; wait tRFC; then IDLE.
- Gap timer: each command loads the timer for its successor. The successor command, or cmd_ready_o rising after RDWR/REF, occurs exactly max(t,1) cycles after the issuing edge.
- Gap values per command: ACT uses tRCD, PRE uses tRP, RD/WR uses tCCD, REF uses tRFC.
- cmd_ready_o = state==IDLE && timer==0 && cfg_enable_i && !refresh_pending && !reset_i.
- Row-hit latency: accept at edge k, RD/WR at edge k+1.
- Refresh counter decrements every cycle while cfg_enable_i is high. At 0 it reloads and sets refresh_pending.
- When pending, in IDLE with timer==0: go to REF_PRE if any bank is open, else straight to REF. refresh_pending clears when REF issues.
- Refresh vs request in the same cycle: refresh wins; ready is already low.
- Counter expiry on the same edge as an accept: the request completes first, then the refresh runs.
- Expiry while already pending: no extra refresh (single flag).
- cfg_enable_i falling mid-operation: the in-flight sequence completes; pending refresh still runs. No new accepts.

Optional Feature:
- SDDR_OPEN_PAGE_EN defined: open-page behaviour as above.
- SDDR_OPEN_PAGE_EN undefined (closed-page):
  - Open-row table is not built.
  - Every access is ACT then RD/WR with A10=1.
  - After RD/WR the gap timer is loaded with tCCD+tRP before ready returns.
  - Refresh skips REF_PRE.

Test Plan:
- Setup for all scenarios: tRCD=3, tRP=2, tRFC=10, tCCD=4, tREFI=200.
- After reset, write bank2 row 0x55 col 0x10 accepted at edge k -> ACT(ba=2, addr=0x55) at k+1; WR(ba=2, addr=0x010) at k+4 with issue_valid_o=1, issue_write_o=1; ready back at k+8.
- Then read bank2 row 0x55 col 0x20 -> no ACT; RD addr=0x020 one cycle after accept; issue_write_o=0.
- Then read bank2 row 0x56 -> PRE(ba=2, addr=0) at k+1, ACT(addr=0x56) at k+3, RD at k+6.
- Let tREFI expire with bank2 open and cmd_valid_i held high -> ready low; PRE-all addr=0x400; REF 2 cycles later; ready returns 10 cycles after REF; next bank2 access issues ACT first.
- Assert reset_i during the tRCD wait -> outputs NOP/0 immediately; after release, a bank2 row 0x56 request issues ACT (table empty).
- Macro undefined, write bank1 row 3 col 8 -> ACT, then WR with addr=0x408 3 cycles later; ready returns 6 cycles after WR.

Source files
------------

// File: rtl/sddr_bank_sched.sv
// DDR3 command scheduler: one request at a time, ACT/RD/WR/PRE/REF on registered PHY pins.
// Define SDDR_OPEN_PAGE_EN for open-page row tracking; default build is closed-page.
module sddr_bank_sched #(
    parameter int unsigned BANK_BITS  = 3,
    parameter int unsigned ROW_BITS   = 13,
    parameter int unsigned COL_BITS   = 10,
    parameter int unsigned TIMER_BITS = 8,
    parameter int unsigned REFI_BITS  = 16
) (
    input  logic                  ddr_clock_i,
    input  logic                  reset_i,
    input  logic                  cfg_enable_i,
    input  logic [TIMER_BITS-1:0] cfg_trcd_i,
    input  logic [TIMER_BITS-1:0] cfg_trp_i,
    input  logic [TIMER_BITS-1:0] cfg_trfc_i,
    input  logic [TIMER_BITS-1:0] cfg_tccd_i,
    input  logic [REFI_BITS-1:0]  cfg_trefi_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [BANK_BITS-1:0]  cmd_bank_i,
    input  logic [ROW_BITS-1:0]   cmd_row_i,
    input  logic [COL_BITS-1:0]   cmd_col_i,
    output logic [3:0]            ddr3_cmd_o,
    output logic [BANK_BITS-1:0]  ddr3_ba_o,
    output logic [ROW_BITS-1:0]   ddr3_addr_o,
    output logic                  issue_valid_o,
    output logic                  issue_write_o,
    output logic                  refresh_busy_o
);
    localparam int unsigned TW = TIMER_BITS + 1;

    localparam logic [3:0] CmdNop = 4'b0111;
    localparam logic [3:0] CmdAct = 4'b0011;
    localparam logic [3:0] CmdRd  = 4'b0101;
    localparam logic [3:0] CmdWr  = 4'b0100;
    localparam logic [3:0] CmdPre = 4'b0010;
    localparam logic [3:0] CmdRef = 4'b0001;

    typedef enum logic [2:0] {StIdle, StPre, StAct, StRdwr, StRefPre, StRef} state_e;

    // Command-to-command gap: successor fires when the timer is seen at 0, t edges later.
    function automatic logic [TW-1:0] gap_cmd(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Command-to-ready gap: ready is combinational, so the timer must read 0 after t edges.
    function automatic logic [TW-1:0] gap_rdy(input logic [TW-1:0] t);
        return (t == '0) ? TW'(1) : t;
    endfunction

    state_e                r_state, w_state_d;
    logic [TW-1:0]         r_timer, w_timer_d;
    logic [3:0]            r_cmd, w_cmd_d;
    logic [BANK_BITS-1:0]  r_ba, w_ba_d;
    logic [ROW_BITS-1:0]   r_addr, w_addr_d;
    logic                  r_iv, w_iv_d;
    logic                  r_iw, w_iw_d;
    logic                  r_rfc_wait, w_rfc_wait_d;
    logic                  r_ref_pending;
    logic [REFI_BITS-1:0]  r_refc;
    logic                  r_req_write;
    logic [BANK_BITS-1:0]  r_req_bank;
    logic [ROW_BITS-1:0]   r_req_row;
    logic [COL_BITS-1:0]   r_req_col;
    logic                  w_accept;
    logic                  w_ref_issue;
    logic                  w_auto_pre;
    logic [TW-1:0]         w_rdwr_gap;

`ifdef SDDR_OPEN_PAGE_EN
    localparam int unsigned NumBanks = 2 ** BANK_BITS;

    logic [NumBanks-1:0]   r_open;
    logic [ROW_BITS-1:0]   r_row [NumBanks];
    logic                  w_pre_issue;
    logic                  w_act_issue;
    logic                  w_bank_open;
    logic                  w_hit;
    logic                  w_any_open;

    assign w_pre_issue = (r_state == StPre) && (r_timer == '0);
    assign w_act_issue = (r_state == StAct) && (r_timer == '0);
    assign w_bank_open = r_open[cmd_bank_i];
    assign w_hit       = w_bank_open && (r_row[cmd_bank_i] == cmd_row_i);
    assign w_any_open  = |r_open;
    assign w_auto_pre  = 1'b0;
    assign w_rdwr_gap  = gap_rdy(TW'(cfg_tccd_i));

    always_ff @(posedge ddr_clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_open <= '0;
        end else if (w_ref_issue) begin
            r_open <= '0;
        end else if (w_pre_issue) begin
            r_open[r_req_bank] <= 1'b0;
        end else if (w_act_issue) begin
            r_open[r_req_bank] <= 1'b1;
        end
    end

    // Row contents are only meaningful while the matching open bit is set.
    always_ff @(posedge ddr_clock_i) begin
        if (w_act_issue) begin
            r_row[r_req_bank] <= r_req_row;
        end
    end
`else
    // Closed page: auto-precharge every access and cover tRP before the next ACT.
    assign w_auto_pre = 1'b1;
    assign w_rdwr_gap = gap_rdy(TW'(cfg_tccd_i) + TW'(cfg_trp_i));
`endif

    assign cmd_ready_o = (r_state == StIdle) && (r_timer == '0) && cfg_enable_i &&
                         !r_ref_pending && !reset_i;
    assign w_accept    = cmd_valid_i && cmd_ready_o;

    always_comb begin
        w_state_d   = r_state;
        w_timer_d   = (r_timer == '0) ? '0 : r_timer - TW'(1);
        w_cmd_d     = CmdNop;
        w_ba_d      = '0;
        w_addr_d    = '0;
        w_iv_d      = 1'b0;
        w_iw_d      = 1'b0;
        w_ref_issue = 1'b0;
        unique case (r_state)
            StIdle: begin
                if ((r_timer == '0) && r_ref_pending) begin
`ifdef SDDR_OPEN_PAGE_EN
                    w_state_d = w_any_open ? StRefPre : StRef;
`else
                    w_state_d = StRef;
`endif
                end else if (w_accept) begin
`ifdef SDDR_OPEN_PAGE_EN
                    if (w_bank_open) begin
                        w_state_d = w_hit ? StRdwr : StPre;
                    end else begin
                        w_state_d = StAct;
                    end
`else
                    w_state_d = StAct;
`endif
                end
            end
            StPre: begin
                if (r_timer == '0) begin
                    w_cmd_d   = CmdPre;
                    w_ba_d    = r_req_bank;
                    w_timer_d = gap_cmd(TW'(cfg_trp_i));
                    w_state_d = StAct;
                end
            end
            StAct: begin
                if (r_timer == '0) begin
                    w_cmd_d   = CmdAct;
                    w_ba_d    = r_req_bank;
                    w_addr_d  = r_req_row;
                    w_timer_d = gap_cmd(TW'(cfg_trcd_i));
                    w_state_d = StRdwr;
                end
            end
            StRdwr: begin
                if (r_timer == '0) begin
                    w_cmd_d      = r_req_write ? CmdWr : CmdRd;
                    w_ba_d       = r_req_bank;
                    w_addr_d     = ROW_BITS'(r_req_col);
                    w_addr_d[10] = w_auto_pre;
                    w_iv_d       = 1'b1;
                    w_iw_d       = r_req_write;
                    w_timer_d    = w_rdwr_gap;
                    w_state_d    = StIdle;
                end
            end
            StRefPre: begin
                if (r_timer == '0) begin
                    w_cmd_d      = CmdPre;
                    w_addr_d[10] = 1'b1;
                    w_timer_d    = gap_cmd(TW'(cfg_trp_i));
                    w_state_d    = StRef;
                end
            end
            StRef: begin
                if (r_timer == '0) begin
                    w_cmd_d     = CmdRef;
                    w_timer_d   = gap_rdy(TW'(cfg_trfc_i));
                    w_ref_issue = 1'b1;
                    w_state_d   = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        w_rfc_wait_d = w_ref_issue ? 1'b1 : ((w_timer_d == '0) ? 1'b0 : r_rfc_wait);
    end

    always_ff @(posedge ddr_clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= StIdle;
            r_timer     <= '0;
            r_cmd       <= CmdNop;
            r_ba        <= '0;
            r_addr      <= '0;
            r_iv        <= 1'b0;
            r_iw        <= 1'b0;
            r_rfc_wait  <= 1'b0;
            r_req_write <= 1'b0;
            r_req_bank  <= '0;
            r_req_row   <= '0;
            r_req_col   <= '0;
        end else begin
            r_state    <= w_state_d;
            r_timer    <= w_timer_d;
            r_cmd      <= w_cmd_d;
            r_ba       <= w_ba_d;
            r_addr     <= w_addr_d;
            r_iv       <= w_iv_d;
            r_iw       <= w_iw_d;
            r_rfc_wait <= w_rfc_wait_d;
            if (w_accept) begin
                r_req_write <= cmd_write_i;
                r_req_bank  <= cmd_bank_i;
                r_req_row   <= cmd_row_i;
                r_req_col   <= cmd_col_i;
            end
        end
    end

    // Expiry on the same edge as REF issue re-arms the flag rather than being lost.
    always_ff @(posedge ddr_clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_refc        <= cfg_trefi_i;
            r_ref_pending <= 1'b0;
        end else begin
            if (w_ref_issue) begin
                r_ref_pending <= 1'b0;
            end
            if (cfg_enable_i) begin
                if (r_refc == '0) begin
                    r_refc        <= cfg_trefi_i;
                    r_ref_pending <= 1'b1;
                end else begin
                    r_refc <= r_refc - REFI_BITS'(1);
                end
            end
        end
    end

    assign ddr3_cmd_o     = r_cmd;
    assign ddr3_ba_o      = r_ba;
    assign ddr3_addr_o    = r_addr;
    assign issue_valid_o  = r_iv;
    assign issue_write_o  = r_iw;
    assign refresh_busy_o = r_ref_pending | r_rfc_wait;

endmodule

// File: tb/tb_sddr_bank_sched.sv
// Directed bench for sddr_bank_sched: per-edge vector tables plus refresh and reset sequences.
// Covers the closed-page build by default and the open-page build when SDDR_OPEN_PAGE_EN is set.
module tb_sddr_bank_sched;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;

    logic        ddr_clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cfg_enable_i = 1'b1;
    logic [7:0]  cfg_trcd_i = 8'd3;
    logic [7:0]  cfg_trp_i = 8'd2;
    logic [7:0]  cfg_trfc_i = 8'd10;
    logic [7:0]  cfg_tccd_i = 8'd4;
    logic [15:0] cfg_trefi_i = 16'd200;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [2:0]  cmd_bank_i = '0;
    logic [12:0] cmd_row_i = '0;
    logic [9:0]  cmd_col_i = '0;
    logic [3:0]  ddr3_cmd_o;
    logic [2:0]  ddr3_ba_o;
    logic [12:0] ddr3_addr_o;
    logic        issue_valid_o;
    logic        issue_write_o;
    logic        refresh_busy_o;

    sddr_bank_sched #(
        .BANK_BITS (3),
        .ROW_BITS  (13),
        .COL_BITS  (10),
        .TIMER_BITS(8),
        .REFI_BITS (16)
    ) dut (
        .ddr_clock_i   (ddr_clock_i),
        .reset_i       (reset_i),
        .cfg_enable_i  (cfg_enable_i),
        .cfg_trcd_i    (cfg_trcd_i),
        .cfg_trp_i     (cfg_trp_i),
        .cfg_trfc_i    (cfg_trfc_i),
        .cfg_tccd_i    (cfg_tccd_i),
        .cfg_trefi_i   (cfg_trefi_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_write_i   (cmd_write_i),
        .cmd_bank_i    (cmd_bank_i),
        .cmd_row_i     (cmd_row_i),
        .cmd_col_i     (cmd_col_i),
        .ddr3_cmd_o    (ddr3_cmd_o),
        .ddr3_ba_o     (ddr3_ba_o),
        .ddr3_addr_o   (ddr3_addr_o),
        .issue_valid_o (issue_valid_o),
        .issue_write_o (issue_write_o),
        .refresh_busy_o(refresh_busy_o)
    );

    always #5 ddr_clock_i = ~ddr_clock_i;

    typedef struct {
        logic        v;
        logic        w;
        logic [2:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [12:0] addr;
        logic        iv;
        logic        iw;
        logic        rdy;
    } vec_t;

    vec_t tv[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic v, input logic w, input logic [2:0] bank,
                                input logic [12:0] row, input logic [9:0] col,
                                input logic [3:0] cmd, input logic [2:0] ba,
                                input logic [12:0] addr, input logic iv, input logic iw,
                                input logic rdy);
        vec_t r;
        r.v = v; r.w = w; r.bank = bank; r.row = row; r.col = col;
        r.cmd = cmd; r.ba = ba; r.addr = addr; r.iv = iv; r.iw = iw; r.rdy = rdy;
        return r;
    endfunction

    // n idle-input edges expecting NOP; only the last carries last_rdy.
    task automatic add_nops(input int n, input logic last_rdy);
        for (int i = 0; i < n; i++) begin
            tv.push_back(mk(0, 0, 0, 0, 0, NOP, 0, 0, 0, 0, (i == n - 1) ? last_rdy : 1'b0));
        end
    endtask

    function automatic logic [31:0] outs();
        return {9'd0, ddr3_cmd_o, ddr3_ba_o, ddr3_addr_o, issue_valid_o, issue_write_o,
                cmd_ready_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ddr_clock_i);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [2:0] b,
                           input logic [12:0] r, input logic [9:0] c);
        cmd_valid_i = v; cmd_write_i = w; cmd_bank_i = b; cmd_row_i = r; cmd_col_i = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   pre_edge;
        logic pre_seen;
        logic rdy_seen;
        logic [31:0] exp;

        // Reset state
        step(); step(); step();
        check("reset_outs", outs(), {9'd0, NOP, 3'd0, 13'd0, 3'b000});
        check("reset_busy", 32'(refresh_busy_o), 32'd0);
        reset_i = 1'b0;
        #1;
        check("ready_after_reset", 32'(cmd_ready_o), 32'd1);
        cfg_enable_i = 1'b0;
        #1;
        check("ready_disabled", 32'(cmd_ready_o), 32'd0);
        cfg_enable_i = 1'b1;
        #1;

`ifdef SDDR_OPEN_PAGE_EN
        // Cold write, row hit read, row miss read.
        tv.push_back(mk(1, 1, 2, 13'h55, 10'h10, NOP, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, ACT, 2, 13'h55, 0, 0, 0));
        add_nops(2, 0);
        tv.push_back(mk(0, 0, 0, 0, 0, WR, 2, 13'h010, 1, 1, 0));
        add_nops(4, 1);
        tv.push_back(mk(1, 0, 2, 13'h55, 10'h20, NOP, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, RD, 2, 13'h020, 1, 0, 0));
        add_nops(4, 1);
        tv.push_back(mk(1, 0, 2, 13'h56, 10'h44, NOP, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, PRE, 2, 13'h000, 0, 0, 0));
        add_nops(1, 0);
        tv.push_back(mk(0, 0, 0, 0, 0, ACT, 2, 13'h56, 0, 0, 0));
        add_nops(2, 0);
        tv.push_back(mk(0, 0, 0, 0, 0, RD, 2, 13'h044, 1, 0, 0));
        add_nops(4, 1);
`else
        // Closed page: every access opens the row and auto-precharges.
        tv.push_back(mk(1, 1, 1, 13'h003, 10'h08, NOP, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, ACT, 1, 13'h003, 0, 0, 0));
        add_nops(2, 0);
        tv.push_back(mk(0, 0, 0, 0, 0, WR, 1, 13'h408, 1, 1, 0));
        add_nops(6, 1);
        tv.push_back(mk(1, 0, 1, 13'h003, 10'h20, NOP, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, ACT, 1, 13'h003, 0, 0, 0));
        add_nops(2, 0);
        tv.push_back(mk(0, 0, 0, 0, 0, RD, 1, 13'h420, 1, 0, 0));
        add_nops(6, 1);
`endif

        foreach (tv[i]) begin
            set_req(tv[i].v, tv[i].w, tv[i].bank, tv[i].row, tv[i].col);
            step();
            exp = {9'd0, tv[i].cmd, tv[i].ba, tv[i].addr, tv[i].iv, tv[i].iw, tv[i].rdy};
            check($sformatf("vec[%0d]", i), outs(), exp);
        end

        // Refresh with a request held on the port.
        set_req(1, 0, 2, 13'h56, 10'h20);
        n = 0;
        while (!refresh_busy_o && n < 400) begin
            step();
            n++;
        end
        check("busy_rise", 32'(refresh_busy_o), 32'd1);
        check("ready_low_on_pending", 32'(cmd_ready_o), 32'd0);
        n = 0;
        pre_edge = -100;
        pre_seen = 1'b0;
        rdy_seen = 1'b0;
        while (ddr3_cmd_o != REF && n < 60) begin
            step();
            n++;
            if (cmd_ready_o) rdy_seen = 1'b1;
            if (ddr3_cmd_o == PRE && ddr3_addr_o == 13'h400 && ddr3_ba_o == 3'd0) begin
                pre_seen = 1'b1;
                pre_edge = n;
            end
        end
        check("ref_issued", 32'(ddr3_cmd_o), 32'(REF));
        check("ready_low_until_ref", 32'(rdy_seen), 32'd0);
`ifdef SDDR_OPEN_PAGE_EN
        check("preall_to_ref_gap", 32'(n - pre_edge), 32'd2);
`else
        check("no_preall_closed", 32'(pre_seen), 32'd0);
`endif
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("trfc_ready[%0d]", k), 32'(cmd_ready_o), 32'(k == 10));
            check($sformatf("trfc_busy[%0d]", k), 32'(refresh_busy_o), 32'(k != 10));
        end
        step();
        check("post_ref_accept", outs(), {9'd0, NOP, 3'd0, 13'd0, 3'b000});
        step();
        check("post_ref_act", outs(), {9'd0, ACT, 3'd2, 13'h56, 3'b000});

        // Reset during the tRCD wait.
        reset_i = 1'b1;
        #1;
        check("async_reset_outs", outs(), {9'd0, NOP, 3'd0, 13'd0, 3'b000});
        check("async_reset_busy", 32'(refresh_busy_o), 32'd0);
        step();
        reset_i = 1'b0;
        #1;
        check("ready_after_rereset", 32'(cmd_ready_o), 32'd1);
        step();
        check("rereset_accept", outs(), {9'd0, NOP, 3'd0, 13'd0, 3'b000});
        set_req(0, 0, 0, 0, 0);
        step();
        check("rereset_act", outs(), {9'd0, ACT, 3'd2, 13'h56, 3'b000});
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
